// File: rtl/alu_seq_if.sv
// Operand/opcode request and result/status bundle for the alu_seq sequencer.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 3
);
   logic                 init;
   logic [WIDTH-1:0]     portA;
   logic [WIDTH-1:0]     portB;
   logic [2:0]           opcode;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;
   logic                 done;
   logic                 err;

   modport master (
      output init, portA, portB, opcode,
      input  result, busy, done, err
   );

   modport slave (
      input  init, portA, portB, opcode,
      output result, busy, done, err
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: shl, shr, zero-test, restoring divide and optional shift-add
// multiply (compiled only when ALU_SEQ_MUL_EN is defined; otherwise opcode 100 is invalid).
module alu_seq #(
   parameter int unsigned WIDTH = 3
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam int unsigned RW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] NSteps = WIDTH'(WIDTH);

   localparam logic [2:0] OpShl  = 3'b000;
   localparam logic [2:0] OpShr  = 3'b001;
   localparam logic [2:0] OpZero = 3'b010;
   localparam logic [2:0] OpDiv  = 3'b011;
   localparam logic [2:0] OpMul  = 3'b100;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    work_q, work_d;
   logic [RW-1:0]    result_q, result_d;
   logic             err_q, err_d;
   logic [WIDTH:0]   rem_try;
`ifdef ALU_SEQ_MUL_EN
   logic [RW-1:0]    acc_q, acc_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         work_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
`endif
      end
   end

   // work_q holds the shifted value, or {remainder, quotient} during division,
   // or the shifted multiplicand during multiplication.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      result_d = result_q;
      err_d    = err_q;
      rem_try  = work_q[RW-1:WIDTH-1];
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.init) begin
               state_d = StRun;
               op_d    = bus.opcode;
               opb_d   = bus.portB;
               work_d  = {{WIDTH{1'b0}}, bus.portA};
`ifdef ALU_SEQ_MUL_EN
               acc_d   = '0;
`endif
               case (bus.opcode)
                  OpShl, OpShr: cnt_d = bus.portB;
                  OpDiv:        cnt_d = (bus.portB == '0) ? '0 : NSteps;
`ifdef ALU_SEQ_MUL_EN
                  OpMul:        cnt_d = NSteps;
`endif
                  default:      cnt_d = '0;
               endcase
            end
         end
         StRun: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               case (op_q)
                  OpShl: work_d = work_q << 1;
                  OpShr: work_d = work_q >> 1;
                  OpDiv: begin
                     // Restoring step: shift {rem, quot} left, subtract if it fits.
                     if (rem_try >= {1'b0, opb_q}) begin
                        work_d = {rem_try[WIDTH-1:0] - opb_q, work_q[WIDTH-2:0], 1'b1};
                     end else begin
                        work_d = {rem_try[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
                     end
                  end
`ifdef ALU_SEQ_MUL_EN
                  OpMul: begin
                     if (opb_q[0]) begin
                        acc_d = acc_q + work_q;
                     end
                     work_d = work_q << 1;
                     opb_d  = opb_q >> 1;
                  end
`endif
                  default: ;
               endcase
            end else begin
               state_d = StDone;
               err_d   = 1'b0;
               case (op_q)
                  OpShl, OpShr: result_d = work_q;
                  OpZero:       result_d = {{(RW-1){1'b0}}, (work_q == '0)};
                  OpDiv: begin
                     if (opb_q == '0) begin
                        result_d = {work_q[WIDTH-1:0], {WIDTH{1'b1}}};
                        err_d    = 1'b1;
                     end else begin
                        result_d = work_q;
                     end
                  end
`ifdef ALU_SEQ_MUL_EN
                  OpMul:        result_d = acc_q;
`endif
                  default: begin
                     result_d = '0;
                     err_d    = 1'b1;
                  end
               endcase
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign bus.result = result_q;
   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = (state_q == StDone);
   assign bus.err    = err_q;

endmodule
